// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative 32-bit unsigned divider between two
// requesters: signed-operand handling, divide-by-zero bypass and a wait watchdog.
module divider_arbiter #(
  parameter int unsigned TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [1:0]  req_signed,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_quo,
  output logic [31:0] resp_rem,
  output logic        resp_dbz,
  output logic        resp_tmo,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  input  logic        div_finish
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic            id;
  logic            rr_ptr;
  logic            neg_q, neg_r;
  logic [WD_W-1:0] wd;

  logic            grant_id;
  logic            accept;
  logic [31:0]     a_sel, b_sel;
  logic            sgn_sel;
  logic            finish_ok;
  logic            wd_expired;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  assign grant_id = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
  assign accept   = !rst && (state == IDLE) && (|req_valid);
  assign a_sel    = grant_id ? req_a[63:32] : req_a[31:0];
  assign b_sel    = grant_id ? req_b[63:32] : req_b[31:0];
  assign sgn_sel  = req_signed[grant_id];

  assign req_ready  = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign div_start  = rst | (state == ISSUE);

  // The first WAIT cycle may still see the previous operation's finish level.
  assign finish_ok  = div_finish && (wd != '0);
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (b_sel == '0) ? RESP : ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (finish_ok || wd_expired) state_next = RESP;
      RESP:  if (resp_ready[id]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      id       <= 1'b0;
      rr_ptr   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      wd       <= '0;
      div_a    <= '0;
      div_b    <= '0;
      resp_quo <= '0;
      resp_rem <= '0;
      resp_dbz <= 1'b0;
      resp_tmo <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            id     <= grant_id;
            rr_ptr <= ~grant_id;
            neg_q  <= sgn_sel & (a_sel[31] ^ b_sel[31]);
            neg_r  <= sgn_sel & a_sel[31];
            resp_tmo <= 1'b0;
            if (b_sel == '0) begin
              resp_quo <= 32'hFFFF_FFFF;
              resp_rem <= a_sel;
              resp_dbz <= 1'b1;
            end else begin
              div_a    <= magnitude(a_sel, sgn_sel);
              div_b    <= magnitude(b_sel, sgn_sel);
              resp_dbz <= 1'b0;
            end
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          if (finish_ok) begin
            resp_quo <= neg_q ? -div_quo : div_quo;
            resp_rem <= neg_r ? -div_rem : div_rem;
          end else if (wd_expired) begin
            resp_quo <= '0;
            resp_rem <= '0;
            resp_tmo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboarded bench for divider_arbiter with a behavioural iterative divider
// that leaves a stale finish level high into the next operation's first cycle.
module tb_divider_arbiter;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_signed;
  logic [63:0] req_a, req_b;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_quo, resp_rem;
  logic        resp_dbz, resp_tmo;
  logic [31:0] div_a, div_b, div_quo, div_rem;
  logic        div_start, div_finish;

  divider_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quo(resp_quo), .resp_rem(resp_rem),
    .resp_dbz(resp_dbz), .resp_tmo(resp_tmo),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_quo(div_quo), .div_rem(div_rem), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- divider model ----------------
  int          div_lat = 5;
  bit          stuck   = 1'b0;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_ra, m_rb;

  always @(posedge clk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      div_finish <= 1'b0;
      div_quo    <= 32'h0;
      div_rem    <= 32'h0;
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= div_lat;
      m_ra   <= div_a;
      m_rb   <= div_b;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        if (!stuck) begin
          div_finish <= 1'b1;
          div_quo    <= m_ra / m_rb;
          div_rem    <= m_ra % m_rb;
        end
      end else begin
        m_cnt      <= m_cnt - 1;
        div_finish <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        id;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  logic glog[$];
  int   acc_cnt   = 0;
  int   start_cnt = 0;

  function automatic exp_t model(input logic i, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input bit stk);
    exp_t   e;
    longint sa, sb_;
    e.id = i; e.dbz = 1'b0; e.tmo = 1'b0;
    if (b == 32'h0) begin
      e.quo = 32'hFFFF_FFFF; e.rem = a; e.dbz = 1'b1;
    end else if (stk) begin
      e.quo = 32'h0; e.rem = 32'h0; e.tmo = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      sa  = sa / sb_;
      e.quo = sa[31:0];
      sa  = longint'($signed(a)) % sb_;
      e.rem = sa[31:0];
    end else begin
      e.quo = a / b; e.rem = a % b;
    end
    return e;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    longint x;
    x = s ? longint'($signed(v)) : longint'({32'h0, v});
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  always @(negedge clk) begin
    logic i;
    exp_t e;
    if (!rst) begin
      if (div_start) start_cnt++;
      if (|(req_valid & req_ready)) begin
        i = req_ready[1];
        sb.push_back(model(i, i ? req_a[63:32] : req_a[31:0],
                           i ? req_b[63:32] : req_b[31:0], req_signed[i], stuck));
        glog.push_back(i);
        acc_cnt++;
      end
      if (|(resp_valid & resp_ready)) begin
        if (sb.size() == 0) check("unexpected_resp", {62'h0, resp_valid}, 64'h0);
        else begin
          e = sb.pop_front();
          check("resp_id",  {62'h0, resp_valid}, e.id ? 64'h2 : 64'h1);
          check("resp_quo", {32'h0, resp_quo}, {32'h0, e.quo});
          check("resp_rem", {32'h0, resp_rem}, {32'h0, e.rem});
          check("resp_dbz", {63'h0, resp_dbz}, {63'h0, e.dbz});
          check("resp_tmo", {63'h0, resp_tmo}, {63'h0, e.tmo});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_signed[i] = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 100);
    if (!req_ready[i]) check("accept_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    if (b != 32'h0) begin
      check("div_start", {63'h0, div_start}, 64'h1);
      check("div_a", {32'h0, div_a}, {32'h0, abs32(a, s)});
      check("div_b", {32'h0, div_b}, {32'h0, abs32(b, s)});
    end else begin
      check("dbz_latency", {62'h0, resp_valid}, (i == 1) ? 64'h2 : 64'h1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'h0, 64'h1);
    @(negedge clk);
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    int s0 = start_cnt;
    issue(i, a, b, s);
    drain();
    check("start_pulses", 64'(start_cnt - s0), (b != 32'h0) ? 64'h1 : 64'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    glog.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int   n, base;
    logic any;

    rst = 1'b1;
    req_valid = '0; req_signed = '0; req_a = '0; req_b = '0;
    resp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  {62'h0, req_ready}, 64'h0);
    check("rst_resp_valid", {62'h0, resp_valid}, 64'h0);
    check("rst_quo_rem",    {resp_quo, resp_rem}, 64'h0);
    check("rst_flags",      {62'h0, resp_dbz, resp_tmo}, 64'h0);
    check("rst_div_ab",     {div_a, div_b}, 64'h0);
    check("rst_div_start",  {63'h0, div_start}, 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic unsigned, signed, INT_MIN/-1 and divide-by-zero
    run_op(0, 32'd100, 32'd7, 1'b0);
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(0, 32'd55, 32'd0, 1'b0);
    run_op(1, 32'h8000_0000, 32'd0, 1'b1);
    run_op(0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    run_op(0, 32'hFFFF_FFF0, 32'd3, 1'b0);

    // Both requesters continuously valid from reset
    do_reset();
    base = acc_cnt;
    @(posedge clk); #1;
    req_a = {32'd91, 32'd40}; req_b = {32'd4, 32'd6}; req_signed = 2'b00;
    req_valid = 2'b11;
    n = 0;
    while (acc_cnt - base < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    check("rr_count", 64'(glog.size()), 64'd4);
    for (int k = 0; k < 4 && k < glog.size(); k++)
      check($sformatf("rr_grant%0d", k), {63'h0, glog[k]}, 64'(k % 2));

    // Response back-pressure; non-owner ready must be ignored
    resp_ready = 2'b10;
    issue(0, 32'd1000, 32'd9, 1'b0);
    @(posedge clk); #1;
    req_a[63:32] = 32'd300; req_b[63:32] = 32'd7; req_signed[1] = 1'b0;
    req_valid[1] = 1'b1;
    n = 0;
    while (resp_valid == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", {62'h0, resp_valid}, 64'h1);
      check("stall_bus",   {resp_quo, resp_rem}, {32'd111, 32'd1});
      check("stall_ready", {62'h0, req_ready}, 64'h0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_ready", {62'h0, req_ready}, 64'h2);
    check("post_hs_valid", {62'h0, resp_valid}, 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Random mix
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op($urandom_range(0, 1), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Watchdog
    stuck = 1'b1;
    issue(0, 32'd9, 32'd3, 1'b0);
    n = 0;
    while (resp_valid == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 64'(n), 64'(TMO + 1));
    drain();
    stuck = 1'b0;
    run_op(1, 32'd81, 32'd9, 1'b0);

    // Reset in the middle of WAIT discards the operation
    div_lat = 20;
    issue(1, 32'd5000, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {62'h0, resp_valid}, 64'h0);
    check("mid_rst_bus",   {resp_quo, resp_rem}, 64'h0);
    check("mid_rst_div",   {div_a, div_b}, 64'h0);
    check("mid_rst_flags", {61'h0, resp_dbz, resp_tmo, div_start}, 64'h1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      any = any | (|resp_valid);
    end
    check("no_stale_resp", {63'h0, any}, 64'h0);
    div_lat = 5;
    run_op(0, 32'd64, 32'd8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Shares one iterative 32-bit unsigned restoring divider between two requesters. Per request it arbitrates round-robin, converts signed operands to magnitudes, and pulses the divider start. It then waits for divider finish, sign-corrects the results and returns them on a per-requester valid/ready response channel. Divide-by-zero is short-circuited without using the divider, and a watchdog bounds the wait.

Parameters:
TIMEOUT, 80, max cycles in WAIT before aborting with resp_tmo; must be >= 40.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted when valid&ready
req_a  in  64  dividends {a1,a0}
req_b  in  64  divisors {b1,b0}
req_signed  in  2  1 = two's-complement operands
resp_valid  out  2  response valid, bit i = requester i
resp_ready  in  2  response consumed when valid&ready
resp_quo  out  32  quotient, shared bus
resp_rem  out  32  remainder, shared bus
resp_dbz  out  1  divisor was zero
resp_tmo  out  1  watchdog expired
div_a  out  32  divider dividend (magnitude)
div_b  out  32  divider divisor (magnitude)
div_start  out  1  divider start pulse (divider's positive-to-start input)
div_quo  in  32  divider quotient, low 32 bits
div_rem  in  32  divider remainder
div_finish  in  1  divider halted/done

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_quo=0, resp_rem=0, resp_dbz=0, resp_tmo=0, div_a=0, div_b=0, state=IDLE, rr_ptr=0 (requester 0 preferred), watchdog=0.
- div_start = rst | (state==ISSUE), so the divider sequencer is reset together with this block.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE grant is combinational:
  - Exactly one requester valid: grant it.
  - Both valid: grant rr_ptr.
  - req_ready=1 only for the granted bit.
- On accept: latch id, a, b, signed flag; rr_ptr <= ~id.
- Magnitudes: if signed and operand[31]=1, magnitude = -operand (32-bit wrap, so 0x80000000 stays 0x80000000). Otherwise the operand is used unchanged.
- neg_q = signed & (a[31]^b[31]); neg_r = signed & a[31].
- Accept with b==0:
  - Skip the divider and go directly to RESP.
  - resp_quo=0xFFFFFFFF, resp_rem=a (raw), resp_dbz=1.
  - Latency: accept at cycle t gives resp_valid at t+1.
- Accept with b!=0: ISSUE for 1 cycle. div_a/div_b are registered magnitudes, held constant from ISSUE until leaving WAIT.
- WAIT:
  - div_finish is ignored in the first WAIT cycle (stale finish from a previous op).
  - From the second cycle, div_finish=1 captures the results and enters RESP the next edge:
    - resp_quo = neg_q ? -div_quo : div_quo
    - resp_rem = neg_r ? -div_rem : div_rem
  - A watchdog counts WAIT cycles. On reaching TIMEOUT: RESP with resp_tmo=1, resp_quo=0, resp_rem=0.
- RESP:
  - resp_valid[id]=1; shared bus and flags stable.
  - Held until resp_ready[id]=1, then next state is IDLE.
  - The earliest new accept is the cycle after the handshake; there is no same-cycle bypass.
  - resp_ready of the non-owner is ignored.
- resp_dbz/resp_tmo are cleared on entry to ISSUE or RESP as appropriate; they are meaningful only while resp_valid.
- INT_MIN / -1 (signed): quo=0x80000000, rem=0; no special flag.
- Request lines in states other than IDLE are ignored, with req_ready=0. A requester may hold valid indefinitely.
- Async rst in any state:
  - Immediately forces IDLE and the output reset values.
  - An in-flight result is discarded; no response is produced.

Test Plan:
1. Req0 unsigned a=100, b=7 -> one div_start pulse, then resp_valid=01, quo=14, rem=2, dbz=0, tmo=0.
2. Req1 signed a=0xFFFFFFF9 (-7), b=2 -> div_a=7, div_b=2; quo=0xFFFFFFFD, rem=0xFFFFFFFF. Also signed 0x80000000 / 0xFFFFFFFF -> quo=0x80000000, rem=0.
3. Req0 a=55, b=0 -> no div_start; resp_valid at accept+1, quo=0xFFFFFFFF, rem=55, dbz=1.
4. Both valid every cycle from reset, 4 ops -> grant order 0,1,0,1; each response goes to the matching resp_valid bit.
5. Hold resp_ready=0 for 10 cycles -> resp_valid and bus stable, no new req_ready. Release -> IDLE the next cycle.
6. Model div_finish stuck 0 with TIMEOUT=40 -> resp_tmo=1 after 40 WAIT cycles. Separately, rst asserted mid-WAIT -> all outputs 0 and no stale response after release.
